// File: rtl/softmax_rd_addr_gen.sv
// rtl/softmax_rd_addr_gen.sv - AXI AR burst generator walking the feature map in softmax order
//
// Walks h -> w-tile -> pass -> channel-group and issues one AR burst per step.
// Each w-tile is read NUM_PASS times: pass 0 for the row max/sum, pass 1 for
// the normalize step. The number of issued-but-uncompleted bursts is capped
// at MAX_OUTSTANDING.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               one-cycle launch pulse; ignored while busy
//   cfg_*               geometry and strides, latched on an accepted start
//   m_arvalid/m_arready AR handshake
//   m_araddr, m_arlen   burst start address, constant AXI_BURST_LEN-1
//   rlast_hs            one burst fully returned
//   tile_pass           pass index of the burst on AR
//   busy, done          run in progress, one-cycle completion pulse
//   perf_cnt            busy-cycle count of the last or current run
module softmax_rd_addr_gen #(
    parameter int ADDR_W          = 32,
    parameter int DAT_BYTES       = 32,
    parameter int AXI_BURST_LEN   = 16,
    parameter int NUM_PASS        = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  cfg_head,
    input  logic [CNT_W-1:0]  cfg_win,
    input  logic [CNT_W-1:0]  cfg_ch_div,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W-1:0] cfg_surf_stride,
    input  logic [ADDR_W-1:0] cfg_line_stride,
    output logic              m_arvalid,
    input  logic              m_arready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [7:0]        m_arlen,
    input  logic              rlast_hs,
    output logic              tile_pass,
    output logic              busy,
    output logic              done,
    output logic [31:0]       perf_cnt
);

    localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int PASS_W = (NUM_PASS > 1) ? $clog2(NUM_PASS) : 1;
    localparam logic [ADDR_W-1:0] TILE_BYTES = ADDR_W'(AXI_BURST_LEN * DAT_BYTES);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FIN} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    head_q, head_d;
    logic [CNT_W-1:0]    wtiles_q, wtiles_d;
    logic [CNT_W-1:0]    ch_div_q, ch_div_d;
    logic [ADDR_W-1:0]   surf_q, surf_d;
    logic [ADDR_W-1:0]   line_q, line_d;
    logic [CNT_W-1:0]    h_q, h_d;
    logic [CNT_W-1:0]    wt_q, wt_d;
    logic [CNT_W-1:0]    c_q, c_d;
    logic [PASS_W-1:0]   pass_q, pass_d;
    logic [ADDR_W-1:0]   line_base_q, line_base_d;
    logic [ADDR_W-1:0]   tile_base_q, tile_base_d;
    logic [ADDR_W-1:0]   ch_addr_q, ch_addr_d;
    logic [OUT_W-1:0]    out_q, out_d;
    logic                arvalid_q, arvalid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [31:0]         perf_q, perf_d;

    logic                ar_hs;
    logic                rl_dec;
    logic                last_c, last_p, last_wt, last_h;
    logic [CNT_W-1:0]    start_wtiles;

    assign m_arvalid = arvalid_q;
    assign m_araddr  = ch_addr_q;
    assign m_arlen   = 8'(AXI_BURST_LEN - 1);
    assign tile_pass = pass_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign perf_cnt  = perf_q;

    assign ar_hs   = arvalid_q & m_arready;
    // A completion with nothing outstanding cannot belong to us; drop it.
    assign rl_dec  = rlast_hs & (out_q != '0);
    assign last_c  = (c_q == ch_div_q - CNT_W'(1));
    assign last_p  = (pass_q == PASS_W'(NUM_PASS - 1));
    assign last_wt = (wt_q == wtiles_q - CNT_W'(1));
    assign last_h  = (h_q == head_q - CNT_W'(1));
    assign start_wtiles = CNT_W'(cfg_win / CNT_W'(AXI_BURST_LEN));

    always_comb begin
        state_d     = state_q;
        head_d      = head_q;
        wtiles_d    = wtiles_q;
        ch_div_d    = ch_div_q;
        surf_d      = surf_q;
        line_d      = line_q;
        h_d         = h_q;
        wt_d        = wt_q;
        c_d         = c_q;
        pass_d      = pass_q;
        line_base_d = line_base_q;
        tile_base_d = tile_base_q;
        ch_addr_d   = ch_addr_q;
        arvalid_d   = arvalid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        perf_d      = perf_q;
        out_d       = out_q;

        if (ar_hs && !rl_dec) begin
            out_d = out_q + OUT_W'(1);
        end else if (!ar_hs && rl_dec) begin
            out_d = out_q - OUT_W'(1);
        end

        if (busy_q && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    head_d      = cfg_head;
                    wtiles_d    = start_wtiles;
                    ch_div_d    = cfg_ch_div;
                    surf_d      = cfg_surf_stride;
                    line_d      = cfg_line_stride;
                    h_d         = '0;
                    wt_d        = '0;
                    c_d         = '0;
                    pass_d      = '0;
                    line_base_d = cfg_base;
                    tile_base_d = cfg_base;
                    ch_addr_d   = cfg_base;
                    perf_d      = '0;
                    busy_d      = 1'b1;
                    if ((cfg_head == '0) || (start_wtiles == '0) || (cfg_ch_div == '0)) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (ar_hs) begin
                    if (!last_c) begin
                        c_d       = c_q + CNT_W'(1);
                        ch_addr_d = ch_addr_q + surf_q;
                    end else begin
                        c_d = '0;
                        if (!last_p) begin
                            pass_d    = pass_q + PASS_W'(1);
                            ch_addr_d = tile_base_q;
                        end else begin
                            pass_d = '0;
                            if (!last_wt) begin
                                wt_d        = wt_q + CNT_W'(1);
                                tile_base_d = tile_base_q + TILE_BYTES;
                                ch_addr_d   = tile_base_q + TILE_BYTES;
                            end else begin
                                wt_d = '0;
                                if (!last_h) begin
                                    h_d         = h_q + CNT_W'(1);
                                    line_base_d = line_base_q + line_q;
                                    tile_base_d = line_base_q + line_q;
                                    ch_addr_d   = line_base_q + line_q;
                                end else begin
                                    h_d = '0;
                                end
                            end
                        end
                    end
                    if (last_c && last_p && last_wt && last_h) begin
                        arvalid_d = 1'b0;
                        state_d   = S_DRAIN;
                    end else begin
                        // Use the post-update count so a free slot allows back-to-back issue.
                        arvalid_d = (out_d < OUT_W'(MAX_OUTSTANDING));
                    end
                end else if (!arvalid_q) begin
                    arvalid_d = (out_d < OUT_W'(MAX_OUTSTANDING));
                end
            end
            S_DRAIN: begin
                if (out_q == '0) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            head_q      <= '0;
            wtiles_q    <= '0;
            ch_div_q    <= '0;
            surf_q      <= '0;
            line_q      <= '0;
            h_q         <= '0;
            wt_q        <= '0;
            c_q         <= '0;
            pass_q      <= '0;
            line_base_q <= '0;
            tile_base_q <= '0;
            ch_addr_q   <= '0;
            out_q       <= '0;
            arvalid_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            perf_q      <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            wtiles_q    <= wtiles_d;
            ch_div_q    <= ch_div_d;
            surf_q      <= surf_d;
            line_q      <= line_d;
            h_q         <= h_d;
            wt_q        <= wt_d;
            c_q         <= c_d;
            pass_q      <= pass_d;
            line_base_q <= line_base_d;
            tile_base_q <= tile_base_d;
            ch_addr_q   <= ch_addr_d;
            out_q       <= out_d;
            arvalid_q   <= arvalid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            perf_q      <= perf_d;
        end
    end

endmodule

// File: doc/softmax_rd_addr_gen.md
Name: softmax_rd_addr_gen

Overview:
AXI read-address generator that feeds the softmax datapath. On a start pulse it walks the feature map in softmax order and issues AR bursts, each of AXI_BURST_LEN beats. The map is FP16, Tout channels per beat, stored as CH-group surfaces of H lines by W pixels. Every W-tile is read NUM_PASS times: pass 0 produces the row max/sum, pass 1 produces the normalize step. The block throttles itself by counting outstanding bursts and reports a busy-cycle performance count to the CSR.

Parameters:
ADDR_W, 32, AXI address width
DAT_BYTES, 32, bytes per AXI beat (one pixel of Tout channels)
AXI_BURST_LEN, 16, beats per burst; the W dimension is padded to a multiple of this
NUM_PASS, 2, number of reads of each W-tile
MAX_OUTSTANDING, 4, maximum issued-but-uncompleted bursts
CNT_W, 16, width of the dimension counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle launch pulse
cfg_head  in  CNT_W  H lines (heads)
cfg_win  in  CNT_W  padded W in pixels, a multiple of AXI_BURST_LEN
cfg_ch_div  in  CNT_W  number of channel groups (CH/Tout)
cfg_base  in  ADDR_W  input base byte address
cfg_surf_stride  in  ADDR_W  byte stride between channel groups
cfg_line_stride  in  ADDR_W  byte stride between H lines
m_arvalid  out  1  AR valid
m_arready  in  1  AR ready
m_araddr  out  ADDR_W  burst start byte address
m_arlen  out  8  constant AXI_BURST_LEN-1
rlast_hs  in  1  rvalid & rready & rlast, i.e. one burst completed
tile_pass  out  1  pass index of the burst currently on AR (0 or 1)
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse
perf_cnt  out  32  number of busy cycles in the last or current run

Behaviour:
- Reset values:
  - m_arvalid=0, m_araddr=0, tile_pass=0, busy=0, done=0, perf_cnt=0.
  - All counters are 0 and the FSM is IDLE.
  - Reset mid-run aborts immediately; no further AR is issued.
- FSM states: IDLE, ISSUE, DRAIN, FIN.
- IDLE:
  - On start, all cfg_* are latched, perf_cnt is cleared to 0, and busy is set on the next cycle.
  - If any of head, win/AXI_BURST_LEN, or ch_div is 0, go to FIN and issue no AR.
  - Otherwise go to ISSUE.
- Loop order, outermost first: h in [0,head), wt in [0,win/AXI_BURST_LEN), pass in [0,NUM_PASS), c in [0,ch_div).
- Burst address: base + c*surf_stride + h*line_stride + wt*AXI_BURST_LEN*DAT_BYTES, modulo 2^ADDR_W.
  - Computed with incremental adders only (line_base, tile_base, ch_addr registers); no multipliers.
- ISSUE:
  - m_arvalid is asserted when outstanding < MAX_OUTSTANDING.
  - m_araddr, m_arlen and tile_pass stay stable while m_arvalid=1 and m_arready=0.
  - m_arvalid is never dropped before the handshake.
  - On each m_arvalid & m_arready, the loop advances and the next burst can present on the following cycle, giving back-to-back issue of 1 burst per cycle.
  - After the handshake of the final burst, go to DRAIN.
- Outstanding counter:
  - Increments on the AR handshake and decrements on rlast_hs; when both occur in the same cycle it is unchanged.
  - rlast_hs while the counter is 0 is ignored (saturates at 0).
- DRAIN: wait until outstanding==0, then go to FIN.
- FIN: done=1 for exactly one cycle and busy drops in the same cycle; return to IDLE.
- start while busy is ignored and the latched config is unchanged.
- perf_cnt:
  - Increments on every cycle with busy=1 and holds its value after done.
  - Saturates at 0xFFFFFFFF.
- Start-to-first-AR latency: first m_arvalid appears 2 cycles after the start cycle (latch, then ISSUE).

Test Plan:
- Basic walk. head=2, win=32, ch_div=2, base=0x1000000, surf=0x800, line=0x400, m_arready=1, rlast_hs returned 2 cycles after each AR. Required:
  - 16 bursts in total, all with arlen=15.
  - Addresses in order 0x1000000, 0x1000800, 0x1000000, 0x1000800, 0x1000200, 0x1000A00, … , then the first h=1 burst at 0x1000400.
  - tile_pass sequence 0,0,1,1 repeating.
  - done pulses once.
- Outstanding cap. As the basic walk, but rlast_hs held at 0. Required:
  - Exactly 4 AR handshakes, then m_arvalid=0.
  - One rlast_hs pulse allows exactly one more burst.
- Backpressure. m_arready held low for 5 cycles on the 3rd burst. Required:
  - m_araddr=0x1000000 and tile_pass=1 stay stable throughout.
  - m_arvalid stays 1.
  - Total burst count is still 16.
- Zero dimension. Start with cfg_ch_div=0. Required:
  - No m_arvalid at any point.
  - done pulses 2 cycles after start.
  - perf_cnt=1.
- Start while busy. A second start pulse mid-run with a different cfg_base. Required: it is ignored; the address sequence and burst count are unchanged.
- Reset mid-run. Assert rst after the 5th burst. Required:
  - All outputs return to their reset values immediately.
  - A new start afterwards runs the full walk correctly from burst 0.
